// File: rtl/hazard_unit.sv
// -----------------------------------------------------------------------------
// hazard_unit
//
// Purpose: pipeline hazard controller for a five-stage in-order core.
//   - Operand forwarding select for the execute stage (M over W priority).
//   - Load-use stall (one bubble), branch/jump redirect flush, and a full
//     pipeline freeze while the data memory reports busy.
//   - Two-state RUN/FREEZE tracker with a 16-bit consecutive-busy counter
//     that raises a sticky Mem_Timeout after TIMEOUT_CYCLES busy cycles.
//   - Optional 32-bit stall/flush performance counters, compiled in only when
//     the macro HAZARD_PERF_CNT_EN is defined (tied to zero otherwise).
//
// Parameters:
//   TIMEOUT_CYCLES   consecutive MEM_Busy cycles before Mem_Timeout (1..65535)
//
// Ports:
//   CLK, RST                 clock, synchronous active-high reset
//   RS1_D, RS2_D             decode-stage source register indices
//   RS1_E, RS2_E, RD_E       execute-stage source / destination indices
//   REG_W_En_E               execute-stage register write enable
//   Result_Src_Sel_E         execute-stage result select (2'b01 = load)
//   RD_M, REG_W_En_M         memory-stage destination / write enable
//   RD_W, REG_W_En_W         writeback-stage destination / write enable
//   PC_Src_Sel_E             taken branch or jump resolved in execute
//   MEM_Busy                 data memory not ready; freeze whole pipeline
//   Stall_F/D/E/M            hold PC, IF/ID, ID/EX, EX/MEM
//   Flush_D, Flush_E         insert NOP into IF/ID, ID/EX
//   Forward_A_E, Forward_B_E 00 regfile, 01 writeback, 10 memory-stage ALU
//   Mem_Timeout              sticky memory timeout flag
//   Stall_Count, Flush_Count performance counters (0 unless enabled)
// -----------------------------------------------------------------------------
module hazard_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [4:0]  RS1_D,
  input  logic [4:0]  RS2_D,
  input  logic [4:0]  RS1_E,
  input  logic [4:0]  RS2_E,
  input  logic [4:0]  RD_E,
  input  logic        REG_W_En_E,
  input  logic [1:0]  Result_Src_Sel_E,
  input  logic [4:0]  RD_M,
  input  logic        REG_W_En_M,
  input  logic [4:0]  RD_W,
  input  logic        REG_W_En_W,
  input  logic        PC_Src_Sel_E,
  input  logic        MEM_Busy,
  output logic        Stall_F,
  output logic        Stall_D,
  output logic        Stall_E,
  output logic        Stall_M,
  output logic        Flush_D,
  output logic        Flush_E,
  output logic [1:0]  Forward_A_E,
  output logic [1:0]  Forward_B_E,
  output logic        Mem_Timeout,
  output logic [31:0] Stall_Count,
  output logic [31:0] Flush_Count
);

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_FREEZE = 1'b1
  } state_t;

  localparam logic [15:0] LP_TIMEOUT = TIMEOUT_CYCLES[15:0];
  localparam logic [1:0]  LP_SRC_LOAD = 2'b01;
  localparam logic [1:0]  LP_FWD_NONE = 2'b00;
  localparam logic [1:0]  LP_FWD_WB   = 2'b01;
  localparam logic [1:0]  LP_FWD_MEM  = 2'b10;

  state_t      r_state;
  state_t      w_next_state;
  logic [15:0] r_busy_cnt;
  logic [15:0] w_busy_next;
  logic        r_mem_timeout;
  logic        w_load_use;

  // ---------------------------------------------------------------------------
  // Forwarding: the memory-stage result is younger than writeback, so it wins.
  // ---------------------------------------------------------------------------
  // NOTE: every signal written in an always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    Forward_A_E = LP_FWD_NONE;
    Forward_B_E = LP_FWD_NONE;
    if (REG_W_En_M && (RD_M != 5'd0) && (RD_M == RS1_E))
      Forward_A_E = LP_FWD_MEM;
    else if (REG_W_En_W && (RD_W != 5'd0) && (RD_W == RS1_E))
      Forward_A_E = LP_FWD_WB;
    if (REG_W_En_M && (RD_M != 5'd0) && (RD_M == RS2_E))
      Forward_B_E = LP_FWD_MEM;
    else if (REG_W_En_W && (RD_W != 5'd0) && (RD_W == RS2_E))
      Forward_B_E = LP_FWD_WB;
  end

  // A load in execute whose destination is read by the instruction in decode.
  assign w_load_use = REG_W_En_E && (Result_Src_Sel_E == LP_SRC_LOAD) &&
                      (RD_E != 5'd0) && ((RD_E == RS1_D) || (RD_E == RS2_D));

  // ---------------------------------------------------------------------------
  // Stall / flush priority: freeze > redirect > load-use. Driven straight from
  // MEM_Busy (not the FSM state) so the freeze takes effect in the same cycle.
  // A redirect held in ID/EX during a freeze flushes on the first free cycle.
  // ---------------------------------------------------------------------------
  always_comb begin
    Stall_F = 1'b0;
    Stall_D = 1'b0;
    Stall_E = 1'b0;
    Stall_M = 1'b0;
    Flush_D = 1'b0;
    Flush_E = 1'b0;
    if (MEM_Busy) begin
      Stall_F = 1'b1;
      Stall_D = 1'b1;
      Stall_E = 1'b1;
      Stall_M = 1'b1;
    end else if (PC_Src_Sel_E) begin
      Flush_D = 1'b1;
      Flush_E = 1'b1;
    end else if (w_load_use) begin
      // Hold fetch/decode and bubble execute: exactly one lost cycle.
      Stall_F = 1'b1;
      Stall_D = 1'b1;
      Flush_E = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // RUN/FREEZE tracker and consecutive-busy counter
  // ---------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_RUN:    if (MEM_Busy)  w_next_state = ST_FREEZE;
      ST_FREEZE: if (!MEM_Busy) w_next_state = ST_RUN;
      default:   w_next_state = ST_RUN;
    endcase
  end

  always_comb begin
    w_busy_next = r_busy_cnt;
    if (!MEM_Busy)
      w_busy_next = 16'd0;
    else if (r_state == ST_RUN)
      w_busy_next = 16'd1;
    else if (r_busy_cnt != 16'hFFFF)
      w_busy_next = r_busy_cnt + 16'd1;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state       <= ST_RUN;
      r_busy_cnt    <= 16'd0;
      r_mem_timeout <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_busy_cnt <= w_busy_next;
      // w_busy_next is the count including this cycle, so the flag rises on
      // the edge that closes the TIMEOUT_CYCLES-th busy cycle.
      if (MEM_Busy && (w_busy_next >= LP_TIMEOUT))
        r_mem_timeout <= 1'b1;
    end
  end

  assign Mem_Timeout = r_mem_timeout;

  // ---------------------------------------------------------------------------
  // Performance counters (free-running, wrap at 2^32)
  // ---------------------------------------------------------------------------
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] r_stall_count;
  logic [31:0] r_flush_count;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_stall_count <= 32'd0;
      r_flush_count <= 32'd0;
    end else begin
      if (Stall_D) r_stall_count <= r_stall_count + 32'd1;
      if (Flush_E) r_flush_count <= r_flush_count + 32'd1;
    end
  end

  assign Stall_Count = r_stall_count;
  assign Flush_Count = r_flush_count;
`else
  assign Stall_Count = 32'd0;
  assign Flush_Count = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// -----------------------------------------------------------------------------
// tb_hazard_unit
//
// Self-checking bench for hazard_unit (TIMEOUT_CYCLES = 4). A behavioural
// model derives forwarding, stall/flush, timeout and counter expectations
// from the priority rules; directed scenarios are followed by a randomized
// run. Inputs change 1 time unit after the rising edge, outputs are sampled
// 1 time unit later (combinational) or 1 time unit after an edge (state).
// Define HAZARD_PERF_CNT_EN at compile time to exercise the counters.
// -----------------------------------------------------------------------------
module tb_hazard_unit;

  localparam int TO = 4;

  logic        CLK = 1'b0;
  logic        RST;
  logic [4:0]  RS1_D, RS2_D, RS1_E, RS2_E, RD_E, RD_M, RD_W;
  logic        REG_W_En_E, REG_W_En_M, REG_W_En_W;
  logic [1:0]  Result_Src_Sel_E;
  logic        PC_Src_Sel_E, MEM_Busy;
  logic        Stall_F, Stall_D, Stall_E, Stall_M, Flush_D, Flush_E;
  logic [1:0]  Forward_A_E, Forward_B_E;
  logic        Mem_Timeout;
  logic [31:0] Stall_Count, Flush_Count;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state
  int          m_busy_run  = 0;
  logic        m_timeout   = 1'b0;
  logic [31:0] m_stall_cnt = 32'd0;
  logic [31:0] m_flush_cnt = 32'd0;

  always #5 CLK = ~CLK;

  hazard_unit #(.TIMEOUT_CYCLES(TO)) dut (
    .CLK(CLK), .RST(RST),
    .RS1_D(RS1_D), .RS2_D(RS2_D),
    .RS1_E(RS1_E), .RS2_E(RS2_E), .RD_E(RD_E),
    .REG_W_En_E(REG_W_En_E), .Result_Src_Sel_E(Result_Src_Sel_E),
    .RD_M(RD_M), .REG_W_En_M(REG_W_En_M),
    .RD_W(RD_W), .REG_W_En_W(REG_W_En_W),
    .PC_Src_Sel_E(PC_Src_Sel_E), .MEM_Busy(MEM_Busy),
    .Stall_F(Stall_F), .Stall_D(Stall_D), .Stall_E(Stall_E), .Stall_M(Stall_M),
    .Flush_D(Flush_D), .Flush_E(Flush_E),
    .Forward_A_E(Forward_A_E), .Forward_B_E(Forward_B_E),
    .Mem_Timeout(Mem_Timeout),
    .Stall_Count(Stall_Count), .Flush_Count(Flush_Count)
  );

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  // Forward select for one source index: 2 = memory, 1 = writeback, 0 = none.
  function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
    if (REG_W_En_M && RD_M != 0 && RD_M == rs) return 2'd2;
    if (REG_W_En_W && RD_W != 0 && RD_W == rs) return 2'd1;
    return 2'd0;
  endfunction

  // {Stall_F, Stall_D, Stall_E, Stall_M, Flush_D, Flush_E}
  function automatic logic [5:0] ref_ctrl();
    bit lu;
    lu = REG_W_En_E && Result_Src_Sel_E == 2'b01 && RD_E != 0 &&
         (RD_E == RS1_D || RD_E == RS2_D);
    if (MEM_Busy)     return 6'b111100;
    if (PC_Src_Sel_E) return 6'b000011;
    if (lu)           return 6'b110001;
    return 6'b000000;
  endfunction

  function automatic logic [31:0] exp_stall_count();
`ifdef HAZARD_PERF_CNT_EN
    return m_stall_cnt;
`else
    return 32'd0;
`endif
  endfunction

  function automatic logic [31:0] exp_flush_count();
`ifdef HAZARD_PERF_CNT_EN
    return m_flush_cnt;
`else
    return 32'd0;
`endif
  endfunction

  // Model advances on every rising edge from the inputs held across it.
  always @(posedge CLK) begin
    logic [5:0] c;
    c = ref_ctrl();
    if (RST) begin
      m_busy_run  = 0;
      m_timeout   = 1'b0;
      m_stall_cnt = 32'd0;
      m_flush_cnt = 32'd0;
    end else begin
      if (MEM_Busy) begin
        m_busy_run++;
        if (m_busy_run >= TO) m_timeout = 1'b1;
      end else begin
        m_busy_run = 0;
      end
      if (c[4]) m_stall_cnt = m_stall_cnt + 32'd1;
      if (c[0]) m_flush_cnt = m_flush_cnt + 32'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic idle_inputs();
    RS1_D = 0; RS2_D = 0; RS1_E = 0; RS2_E = 0; RD_E = 0; RD_M = 0; RD_W = 0;
    REG_W_En_E = 0; REG_W_En_M = 0; REG_W_En_W = 0; Result_Src_Sel_E = 0;
    PC_Src_Sel_E = 0; MEM_Busy = 0;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic pulse_reset();
    idle_inputs();
    RST = 1'b1;
    tick();
    RST = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    idle_inputs();
    RST = 1'b1;
    MEM_Busy = 1'b1;
    PC_Src_Sel_E = 1'b1;
    #1;
    n_tests++;
    if ({Stall_F, Stall_D, Stall_E, Stall_M, Flush_D, Flush_E} !== ref_ctrl()) begin
      n_fail++;
      $display("FAIL reset_comb_ctrl: got %b expected %b",
               {Stall_F, Stall_D, Stall_E, Stall_M, Flush_D, Flush_E}, ref_ctrl());
    end
    for (int i = 0; i < 5; i++) tick();
    n_tests++;
    if (Mem_Timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_timeout: got %b expected 0", Mem_Timeout);
    end
    n_tests++;
    if (Stall_Count !== 32'd0 || Flush_Count !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_counters: got %0d/%0d expected 0/0", Stall_Count, Flush_Count);
    end
    RST = 1'b0;
    idle_inputs();
    tick();
  endtask

  task automatic test_forwarding();
    idle_inputs();
    RD_M = 5; REG_W_En_M = 1; RD_W = 5; REG_W_En_W = 1; RS1_E = 5; RS2_E = 0;
    #1;
    n_tests++;
    if (Forward_A_E !== 2'b10 || Forward_B_E !== 2'b00) begin
      n_fail++;
      $display("FAIL fwd_m_priority: got A=%b B=%b expected A=10 B=00", Forward_A_E, Forward_B_E);
    end
    REG_W_En_M = 0; RS2_E = 5;
    #1;
    n_tests++;
    if (Forward_A_E !== 2'b01 || Forward_B_E !== 2'b01) begin
      n_fail++;
      $display("FAIL fwd_w_only: got A=%b B=%b expected A=01 B=01", Forward_A_E, Forward_B_E);
    end
    RD_W = 0; RS1_E = 0; RS2_E = 0;
    #1;
    n_tests++;
    if (Forward_A_E !== 2'b00 || Forward_B_E !== 2'b00) begin
      n_fail++;
      $display("FAIL fwd_x0: got A=%b B=%b expected A=00 B=00", Forward_A_E, Forward_B_E);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_load_use();
    pulse_reset();
    Result_Src_Sel_E = 2'b01; REG_W_En_E = 1; RD_E = 7; RS2_D = 7;
    #1;
    n_tests++;
    if ({Stall_F, Stall_D, Stall_E, Stall_M, Flush_D, Flush_E} !== 6'b110001) begin
      n_fail++;
      $display("FAIL load_use_ctrl: got %b expected 110001",
               {Stall_F, Stall_D, Stall_E, Stall_M, Flush_D, Flush_E});
    end
    tick();
    idle_inputs();  // bubble now occupies execute
    #1;
    n_tests++;
    if ({Stall_F, Stall_D, Stall_E, Stall_M, Flush_D, Flush_E} !== 6'b000000) begin
      n_fail++;
      $display("FAIL load_use_one_bubble: got %b expected 000000",
               {Stall_F, Stall_D, Stall_E, Stall_M, Flush_D, Flush_E});
    end
    n_tests++;
`ifdef HAZARD_PERF_CNT_EN
    if (Stall_Count !== 32'd1) begin
`else
    if (Stall_Count !== 32'd0) begin
`endif
      n_fail++;
      $display("FAIL load_use_stall_count: got %0d expected %0d", Stall_Count, exp_stall_count());
    end
    tick();
  endtask

  task automatic test_redirect_wins();
    logic [31:0] flush_before;
    idle_inputs();
    flush_before = exp_flush_count();
    Result_Src_Sel_E = 2'b01; REG_W_En_E = 1; RD_E = 9; RS1_D = 9; PC_Src_Sel_E = 1;
    #1;
    n_tests++;
    if ({Stall_F, Stall_D, Stall_E, Stall_M, Flush_D, Flush_E} !== 6'b000011) begin
      n_fail++;
      $display("FAIL redirect_wins: got %b expected 000011",
               {Stall_F, Stall_D, Stall_E, Stall_M, Flush_D, Flush_E});
    end
    tick();
    idle_inputs();
    n_tests++;
`ifdef HAZARD_PERF_CNT_EN
    if (Flush_Count !== flush_before + 32'd1) begin
`else
    if (Flush_Count !== 32'd0) begin
`endif
      n_fail++;
      $display("FAIL redirect_flush_count: got %0d expected %0d", Flush_Count, exp_flush_count());
    end
    tick();
  endtask

  task automatic test_freeze_wins();
    idle_inputs();
    MEM_Busy = 1; PC_Src_Sel_E = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_tests++;
      if ({Stall_F, Stall_D, Stall_E, Stall_M, Flush_D, Flush_E} !== 6'b111100) begin
        n_fail++;
        $display("FAIL freeze_wins_cyc%0d: got %b expected 111100", i,
                 {Stall_F, Stall_D, Stall_E, Stall_M, Flush_D, Flush_E});
      end
      tick();
    end
    MEM_Busy = 0;
    #1;
    n_tests++;
    if ({Stall_F, Stall_D, Stall_E, Stall_M, Flush_D, Flush_E} !== 6'b000011) begin
      n_fail++;
      $display("FAIL freeze_release_flush: got %b expected 000011",
               {Stall_F, Stall_D, Stall_E, Stall_M, Flush_D, Flush_E});
    end
    n_tests++;
    if (Mem_Timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL freeze_no_timeout: got %b expected 0", Mem_Timeout);
    end
    tick();
    idle_inputs();
    tick();
  endtask

  task automatic test_timeout();
    pulse_reset();
    MEM_Busy = 1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      n_tests++;
      if (Mem_Timeout !== 1'b0) begin
        n_fail++;
        $display("FAIL timeout_short_run_%0d: got %b expected 0", i, Mem_Timeout);
      end
    end
    MEM_Busy = 0;
    tick();
    MEM_Busy = 1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      n_tests++;
      if (Mem_Timeout !== (i == 4)) begin
        n_fail++;
        $display("FAIL timeout_run_%0d: got %b expected %b", i, Mem_Timeout, i == 4);
      end
    end
    MEM_Busy = 0;
    tick();
    tick();
    n_tests++;
    if (Mem_Timeout !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_sticky: got %b expected 1", Mem_Timeout);
    end
    RST = 1;
    MEM_Busy = 1;  // reset must win over a busy edge
    tick();
    RST = 0;
    MEM_Busy = 0;
    n_tests++;
    if (Mem_Timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_cleared: got %b expected 0", Mem_Timeout);
    end
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      RST              = ($urandom_range(0, 49) == 0);
      RS1_D            = 5'($urandom_range(0, 3));
      RS2_D            = 5'($urandom_range(0, 3));
      RS1_E            = 5'($urandom_range(0, 3));
      RS2_E            = 5'($urandom_range(0, 3));
      RD_E             = 5'($urandom_range(0, 3));
      RD_M             = 5'($urandom_range(0, 3));
      RD_W             = 5'($urandom_range(0, 3));
      REG_W_En_E       = 1'($urandom_range(0, 1));
      REG_W_En_M       = 1'($urandom_range(0, 1));
      REG_W_En_W       = 1'($urandom_range(0, 1));
      Result_Src_Sel_E = 2'($urandom_range(0, 3));
      PC_Src_Sel_E     = ($urandom_range(0, 4) == 0);
      MEM_Busy         = ($urandom_range(0, 2) == 0);
      #1;
      n_tests++;
      if (Forward_A_E !== ref_fwd(RS1_E) || Forward_B_E !== ref_fwd(RS2_E)) begin
        n_fail++;
        $display("FAIL rand_fwd[%0d]: got A=%b B=%b expected A=%b B=%b", i,
                 Forward_A_E, Forward_B_E, ref_fwd(RS1_E), ref_fwd(RS2_E));
      end
      n_tests++;
      if ({Stall_F, Stall_D, Stall_E, Stall_M, Flush_D, Flush_E} !== ref_ctrl()) begin
        n_fail++;
        $display("FAIL rand_ctrl[%0d]: got %b expected %b", i,
                 {Stall_F, Stall_D, Stall_E, Stall_M, Flush_D, Flush_E}, ref_ctrl());
      end
      tick();
      n_tests++;
      if (Mem_Timeout !== m_timeout) begin
        n_fail++;
        $display("FAIL rand_timeout[%0d]: got %b expected %b", i, Mem_Timeout, m_timeout);
      end
      n_tests++;
      if (Stall_Count !== exp_stall_count() || Flush_Count !== exp_flush_count()) begin
        n_fail++;
        $display("FAIL rand_counters[%0d]: got %0d/%0d expected %0d/%0d", i,
                 Stall_Count, Flush_Count, exp_stall_count(), exp_flush_count());
      end
    end
    RST = 0;
    idle_inputs();
    tick();
  endtask

  task automatic test_counter_wrap();
    idle_inputs();
`ifdef HAZARD_PERF_CNT_EN
    force dut.r_stall_count = 32'hFFFF_FFFF;
    #1;
    release dut.r_stall_count;
    m_stall_cnt = 32'hFFFF_FFFF;
    n_tests++;
    if (Stall_Count !== 32'hFFFF_FFFF) begin
      n_fail++;
      $display("FAIL wrap_preload: got %h expected ffffffff", Stall_Count);
    end
    Result_Src_Sel_E = 2'b01; REG_W_En_E = 1; RD_E = 3; RS1_D = 3;
    tick();
    idle_inputs();
    n_tests++;
    if (Stall_Count !== 32'd0) begin
      n_fail++;
      $display("FAIL wrap_to_zero: got %h expected 00000000", Stall_Count);
    end
`else
    MEM_Busy = 1;
    tick();
    MEM_Busy = 0; PC_Src_Sel_E = 1;
    tick();
    idle_inputs();
    n_tests++;
    if (Stall_Count !== 32'd0 || Flush_Count !== 32'd0) begin
      n_fail++;
      $display("FAIL counters_disabled: got %0d/%0d expected 0/0", Stall_Count, Flush_Count);
    end
`endif
    tick();
  endtask

  initial begin
    RST = 1'b1;
    idle_inputs();
    #1;
    test_reset();
    test_forwarding();
    test_load_use();
    test_redirect_wins();
    test_freeze_wins();
    test_timeout();
    test_random();
    test_counter_wrap();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_unit.md
HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, meaning consecutive MEM_Busy cycles before a timeout is flagged (legal range 1..65535).
REQ-002 SHALL have port CLK  in  1  clock; all state updates on rising edge.
REQ-003 SHALL have port RST  in  1  reset, synchronous, active-high.
REQ-004 SHALL have ports RS1_D, RS2_D  in  5 each  decode-stage source register indices.
REQ-005 SHALL have ports RS1_E, RS2_E, RD_E  in  5 each  execute-stage source and destination indices.
REQ-006 SHALL have ports REG_W_En_E  in  1  and Result_Src_Sel_E  in  2  execute-stage write enable and result select (2'b01 = memory load).
REQ-007 SHALL have ports RD_M  in  5  and REG_W_En_M  in  1  memory-stage destination and write enable.
REQ-008 SHALL have ports RD_W  in  5  and REG_W_En_W  in  1  writeback-stage destination and write enable.
REQ-009 SHALL have port PC_Src_Sel_E  in  1  taken branch or jump resolved in execute (redirect).
REQ-010 SHALL have port MEM_Busy  in  1  data memory not ready; the whole pipeline must freeze.
REQ-011 SHALL have ports Stall_F, Stall_D, Stall_E, Stall_M  out  1 each  hold PC and IF/ID, ID/EX, EX/MEM registers.
REQ-012 SHALL have ports Flush_D, Flush_E  out  1 each  insert a NOP into IF/ID and ID/EX.
REQ-013 SHALL have ports Forward_A_E, Forward_B_E  out  2 each  ALU operand select: 00 register file, 01 writeback result, 10 memory-stage ALU result.
REQ-014 SHALL have port Mem_Timeout  out  1  sticky memory-timeout flag.
REQ-015 SHALL have ports Stall_Count, Flush_Count  out  32 each  performance counters.

Function
REQ-016 SHALL drive Forward_A_E = 10 when REG_W_En_M=1, RD_M!=0 and RD_M==RS1_E; otherwise 01 when REG_W_En_W=1, RD_W!=0 and RD_W==RS1_E; otherwise 00. The M stage has priority over W.
REQ-017 SHALL derive Forward_B_E identically using RS2_E; both forwarding outputs are combinational with zero latency.
REQ-018 SHALL define load_use = REG_W_En_E & (Result_Src_Sel_E==01) & (RD_E!=0) & (RD_E==RS1_D | RD_E==RS2_D).
REQ-019 SHALL, when MEM_Busy=1 (freeze), assert all four Stall outputs and hold both Flush outputs at 0, regardless of load_use or PC_Src_Sel_E.
REQ-020 SHALL, when not frozen and PC_Src_Sel_E=1, assert Flush_D=1 and Flush_E=1 with all Stall outputs at 0. A load_use in the same cycle is suppressed.
REQ-021 SHALL, when not frozen, PC_Src_Sel_E=0 and load_use=1, assert Stall_F=1, Stall_D=1 and Flush_E=1, with Stall_E=0, Stall_M=0 and Flush_D=0; this gives exactly one bubble per load-use occurrence.
REQ-022 SHALL drive all Stall and Flush outputs combinationally in the same cycle as their cause.
REQ-023 SHALL implement a two-state FSM:
- RUN goes to FREEZE on an edge with MEM_Busy=1.
- FREEZE goes to RUN on an edge with MEM_Busy=0.
- FREEZE stays in FREEZE otherwise.
REQ-024 SHALL keep a 16-bit busy counter:
- Reloads to 1 on the RUN-to-FREEZE edge.
- Increments (saturating) each further edge with MEM_Busy=1.
- Clears to 0 on an edge with MEM_Busy=0.
REQ-025 SHALL set Mem_Timeout at the edge ending the TIMEOUT_CYCLES-th consecutive MEM_Busy=1 cycle; Mem_Timeout stays set until RST.
REQ-026 SHALL, when MEM_Busy deasserts, resume normally; a redirect still held in ID/EX then produces its flush on the first unfrozen cycle.

Reset
REQ-027 SHALL, on an edge with RST=1, set the FSM to RUN, the busy counter to 0, Mem_Timeout to 0, and Stall_Count and Flush_Count to 0.
REQ-028 SHALL give RST priority over every simultaneous event, including MEM_Busy=1 and a timeout edge; combinational outputs continue to follow their inputs during reset.

Configuration
REQ-029 SHALL compile the performance counters only when macro HAZARD_PERF_CNT_EN is defined:
- Stall_Count increments on each edge where Stall_D=1.
- Flush_Count increments on each edge where Flush_E=1.
- Both counters wrap from 0xFFFFFFFF to 0.
REQ-030 SHALL, without HAZARD_PERF_CNT_EN, tie Stall_Count and Flush_Count to 0 and instantiate no counter flops; all other behaviour is unchanged.

Verification
REQ-031 SHALL cover forwarding: RD_M=5, REG_W_En_M=1, RD_W=5, REG_W_En_W=1, RS1_E=5, RS2_E=0 -> Forward_A_E=10, Forward_B_E=00.
REQ-032 SHALL cover load-use: Result_Src_Sel_E=01, REG_W_En_E=1, RD_E=7, RS2_D=7 -> Stall_F=1, Stall_D=1, Flush_E=1 for one cycle; Stall_Count=1 with the macro defined.
REQ-033 SHALL cover redirect-wins: load_use=1 and PC_Src_Sel_E=1 together -> Flush_D=1, Flush_E=1, all Stall outputs 0; Flush_Count +1.
REQ-034 SHALL cover freeze-wins: MEM_Busy=1 with PC_Src_Sel_E=1 for 3 cycles -> all Stall outputs 1 and no flush; on the first cycle with MEM_Busy=0 -> Flush_D=1 and Flush_E=1.
REQ-035 SHALL cover timeout: TIMEOUT_CYCLES=4, MEM_Busy=1 for 3 cycles -> Mem_Timeout=0; MEM_Busy=1 for 4 cycles -> Mem_Timeout=1 and still 1 after MEM_Busy falls; then RST=1 -> Mem_Timeout=0.
REQ-036 SHALL cover counter wrap: with the macro defined, force Stall_Count to 0xFFFFFFFF and apply one stall cycle -> Stall_Count=0; without the macro, Stall_Count and Flush_Count read 0 throughout.
